ram_wb_arbiter_2m: RTL and testbench
====================================

// Module: ram_wb_arbiter_2m
// PURPOSE
//  Two-master Wishbone B3 arbiter that shares one ram_wb_b3-style slave between an instruction and a data master.
//  Round-robin, never splits a burst, inserts one dead cycle between owners so the slave's registered ack state clears.
//  Watchdog releases a master that holds CYC without completing an access.
// PARAMETERS
//  dw          32   data width (sel is dw/8 = 4 bits)
//  aw          32   address width
//  TIMEOUT     255  cycles with no slave ack/err before forced release; 0 disables
//  FIXED_PRIO  0    1: m0 always wins in IDLE; 0: round-robin
// PORTS  (X = 0,1; mX_* per master, s_* to slave)
//  wb_clk_i       in   1     single clock, rising edge
//  wb_rst_i       in   1     synchronous, active-high reset
//  mX_wb_adr_i    in   aw    | mX_wb_dat_i in dw | mX_wb_sel_i in 4
//  mX_wb_bte_i    in   2     | mX_wb_cti_i in 3  | mX_wb_cyc_i, mX_wb_stb_i, mX_wb_we_i in 1
//  mX_wb_ack_o    out  1     | mX_wb_err_o out 1 | mX_wb_rty_o out 1
//  mX_wb_dat_o    out  dw    slave read data, broadcast to both masters
//  s_wb_adr_o..s_wb_we_o  out  (as mX inputs)  muxed from granted master
//  s_wb_ack_i, s_wb_err_i, s_wb_rty_i in 1; s_wb_dat_i in dw
//  grant_o        out  2     one-hot current owner {m1,m0}; 00 = none
// BEHAVIOUR
//  States: IDLE, GNT0, GNT1 (registered). Reset -> IDLE, grant_o=00, last_owner=1 (m0 wins first), timer=0.
//  Reset values of outputs: all mX ack/err/rty=0; s_wb_cyc_o=s_wb_stb_o=s_wb_we_o=0; dat/adr don't-care.
//  IDLE: s_wb_cyc_o=s_wb_stb_o=0. Requests = mX_wb_cyc_i. One requester -> grant it. Both -> FIXED_PRIO?m0:!last_owner.
//   Grant registers at clock edge; slave sees granted CYC/STB the cycle after request (1-cycle arbitration latency).
//  GNTx: s_wb_* = mX signals combinationally; mX ack/err/rty = s_wb_*_i; other master's ack/err/rty = 0.
//  End-of-access (EOA) = (s_wb_ack_i | s_wb_err_i) & (cti==3'b000 | cti==3'b111 | s_wb_err_i).
//  GNTx -> IDLE (last_owner<=x) when any of:
//   a) mX_wb_cyc_i low (slave CYC dropped same cycle, combinational);
//   b) EOA and other master's CYC high (fair hand-over after single access or end of burst);
//   c) timer == TIMEOUT (TIMEOUT!=0): mX_wb_err_o forced 1 for that cycle, s_wb_cyc_o/stb_o forced 0.
//  No release mid-burst (cti 001/010) except a) or c). Sole requester keeps grant across back-to-back accesses.
//  Timer: width clog2(TIMEOUT+1); clears on grant and on any s_wb_ack_i/err_i; increments in GNTx; saturates; 0 in IDLE.
//  Simultaneous slave err and timeout in same cycle: slave err wins, timer not applied.
//  Reset mid-burst: next cycle IDLE, slave CYC low; in-flight beat discarded, no ack/err to masters.
//  Hand-over always passes through IDLE: >=1 cycle with slave CYC=0 between owners.
//  s_wb_rty_i passed through unmodified; not a release condition.
// STRUCTURE
//  Package ram_wb_arb_pkg: state enum {IDLE,GNT0,GNT1}; CTI_CLASSIC=3'b000, CTI_CONST=3'b001,
//   CTI_INCR=3'b010, CTI_EOB=3'b111; BTE_LINEAR/WRAP4/WRAP8/WRAP16.
//  One sub-module: ram_wb_arb_watchdog (timer, clear/enable, expired flag). FSM and muxes stay in this file.
// TESTING
//  1 Reset 5 cycles, both CYC high -> grant_o=00, s_wb_cyc_o=0, all mX ack/err=0 during reset.
//  2 m0 classic read adr 0x10 alone -> grant_o=01 next cycle, s_wb_adr_o=0x10, m0 ack on slave ack, m1 ack=0.
//  3 m0,m1 CYC rise same cycle after reset, classic accesses -> order m0,m1,m0,m1; 1 IDLE cycle between each.
//  4 m1 4-beat incr wrap burst (cti 010, bte 01, adr 0x08) with m0 waiting -> 4 m1 acks (0x08,0x0C,0x00,0x04),
//    m0 granted only after ack with cti 111; m0 ack=0 throughout.
//  5 TIMEOUT=8: m0 CYC high, STB low -> m0_wb_err_o=1 exactly on 8th granted cycle, IDLE next, m1 served.
//  6 wb_rst_i pulse on beat 2 of m0 burst -> s_wb_cyc_o=0 next cycle, grant_o=00, new m1 request granted cleanly.

Source files
------------

// File: rtl/ram_wb_arb_pkg.sv
// Shared types and Wishbone B3 cycle-type encodings for the two-master RAM arbiter.
package ram_wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    // An access ends on a terminating beat of a classic cycle or burst, or on any error.
    function automatic logic end_of_access(input logic [2:0] cti, input logic ack,
                                           input logic err);
        return (ack | err) & ((cti == CTI_CLASSIC) | (cti == CTI_EOB) | err);
    endfunction

endpackage

// File: rtl/ram_wb_arb_watchdog.sv
// Counts granted cycles without a slave response; flags expiry so a stuck owner can be released.
module ram_wb_arb_watchdog
    import ram_wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] SAT   = CW'(TIMEOUT);
    // The current cycle counts too, so expiry fires on the TIMEOUT-th silent granted cycle.
    localparam logic [CW-1:0] LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] count_q, count_d;

    // Next count: cleared when idle or on a slave response, otherwise saturating increment.
    always_comb begin
        count_d = count_q;
        if (clear || !enable) begin
            count_d = '0;
        end else if (count_q != SAT) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A slave response in the same cycle cancels expiry.
    always_comb begin
        expired = (TIMEOUT != 0) && enable && !clear && (count_q >= LIMIT);
    end

endmodule

// File: rtl/ram_wb_arbiter_2m.sv
// Two-master Wishbone B3 arbiter in front of a single RAM slave: round-robin or fixed priority,
// bursts are never split, and every hand-over passes through an idle cycle.
module ram_wb_arbiter_2m
    import ram_wb_arb_pkg::*;
#(
    parameter int unsigned dw         = 32,
    parameter int unsigned aw         = 32,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,

    input  logic [aw-1:0]   m0_wb_adr_i,
    input  logic [dw-1:0]   m0_wb_dat_i,
    input  logic [dw/8-1:0] m0_wb_sel_i,
    input  logic [1:0]      m0_wb_bte_i,
    input  logic [2:0]      m0_wb_cti_i,
    input  logic            m0_wb_cyc_i,
    input  logic            m0_wb_stb_i,
    input  logic            m0_wb_we_i,
    output logic            m0_wb_ack_o,
    output logic            m0_wb_err_o,
    output logic            m0_wb_rty_o,
    output logic [dw-1:0]   m0_wb_dat_o,

    input  logic [aw-1:0]   m1_wb_adr_i,
    input  logic [dw-1:0]   m1_wb_dat_i,
    input  logic [dw/8-1:0] m1_wb_sel_i,
    input  logic [1:0]      m1_wb_bte_i,
    input  logic [2:0]      m1_wb_cti_i,
    input  logic            m1_wb_cyc_i,
    input  logic            m1_wb_stb_i,
    input  logic            m1_wb_we_i,
    output logic            m1_wb_ack_o,
    output logic            m1_wb_err_o,
    output logic            m1_wb_rty_o,
    output logic [dw-1:0]   m1_wb_dat_o,

    output logic [aw-1:0]   s_wb_adr_o,
    output logic [dw-1:0]   s_wb_dat_o,
    output logic [dw/8-1:0] s_wb_sel_o,
    output logic [1:0]      s_wb_bte_o,
    output logic [2:0]      s_wb_cti_o,
    output logic            s_wb_cyc_o,
    output logic            s_wb_stb_o,
    output logic            s_wb_we_o,
    input  logic            s_wb_ack_i,
    input  logic            s_wb_err_i,
    input  logic            s_wb_rty_i,
    input  logic [dw-1:0]   s_wb_dat_i,

    output logic [1:0]      grant_o
);

    arb_state_e state_q, state_d;
    logic       last_owner_q, last_owner_d;  // 0: m0 owned last, 1: m1 owned last
    logic       sel_m1;
    logic       wd_clear, wd_enable, wd_expired;

    ram_wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    assign wd_enable = (state_q != IDLE);
    assign wd_clear  = s_wb_ack_i | s_wb_err_i;

    // Payload mux; cyc/stb/we are qualified by ownership below, so IDLE contents don't matter.
    assign sel_m1      = (state_q == GNT1);
    assign s_wb_adr_o  = sel_m1 ? m1_wb_adr_i : m0_wb_adr_i;
    assign s_wb_dat_o  = sel_m1 ? m1_wb_dat_i : m0_wb_dat_i;
    assign s_wb_sel_o  = sel_m1 ? m1_wb_sel_i : m0_wb_sel_i;
    assign s_wb_bte_o  = sel_m1 ? m1_wb_bte_i : m0_wb_bte_i;
    assign s_wb_cti_o  = sel_m1 ? m1_wb_cti_i : m0_wb_cti_i;
    assign m0_wb_dat_o = s_wb_dat_i;
    assign m1_wb_dat_o = s_wb_dat_i;

    // Grant follows the registered owner, blanked while reset is asserted.
    assign grant_o = {(state_q == GNT1), (state_q == GNT0)} & ~{2{wb_rst_i}};

    // Arbitration, release conditions and owner-side control/response routing.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        s_wb_cyc_o   = 1'b0;
        s_wb_stb_o   = 1'b0;
        s_wb_we_o    = 1'b0;
        m0_wb_ack_o  = 1'b0;
        m0_wb_err_o  = 1'b0;
        m0_wb_rty_o  = 1'b0;
        m1_wb_ack_o  = 1'b0;
        m1_wb_err_o  = 1'b0;
        m1_wb_rty_o  = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_wb_cyc_i && m1_wb_cyc_i) begin
                    state_d = ((FIXED_PRIO != 0) || last_owner_q) ? GNT0 : GNT1;
                end else if (m0_wb_cyc_i) begin
                    state_d = GNT0;
                end else if (m1_wb_cyc_i) begin
                    state_d = GNT1;
                end
            end

            GNT0: begin
                s_wb_cyc_o  = m0_wb_cyc_i;
                s_wb_stb_o  = m0_wb_stb_i;
                s_wb_we_o   = m0_wb_we_i;
                m0_wb_ack_o = s_wb_ack_i;
                m0_wb_err_o = s_wb_err_i;
                m0_wb_rty_o = s_wb_rty_i;
                if (!m0_wb_cyc_i) begin
                    state_d      = IDLE;
                    last_owner_d = 1'b0;
                end else if (end_of_access(m0_wb_cti_i, s_wb_ack_i, s_wb_err_i) && m1_wb_cyc_i) begin
                    state_d      = IDLE;
                    last_owner_d = 1'b0;
                end else if (wd_expired) begin
                    // Stuck owner: terminate its cycle with an error and pull the slave off the bus.
                    m0_wb_err_o  = 1'b1;
                    s_wb_cyc_o   = 1'b0;
                    s_wb_stb_o   = 1'b0;
                    state_d      = IDLE;
                    last_owner_d = 1'b0;
                end
            end

            GNT1: begin
                s_wb_cyc_o  = m1_wb_cyc_i;
                s_wb_stb_o  = m1_wb_stb_i;
                s_wb_we_o   = m1_wb_we_i;
                m1_wb_ack_o = s_wb_ack_i;
                m1_wb_err_o = s_wb_err_i;
                m1_wb_rty_o = s_wb_rty_i;
                if (!m1_wb_cyc_i) begin
                    state_d      = IDLE;
                    last_owner_d = 1'b1;
                end else if (end_of_access(m1_wb_cti_i, s_wb_ack_i, s_wb_err_i) && m0_wb_cyc_i) begin
                    state_d      = IDLE;
                    last_owner_d = 1'b1;
                end else if (wd_expired) begin
                    m1_wb_err_o  = 1'b1;
                    s_wb_cyc_o   = 1'b0;
                    s_wb_stb_o   = 1'b0;
                    state_d      = IDLE;
                    last_owner_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Whatever is in flight while reset is asserted is discarded on both sides.
        if (wb_rst_i) begin
            s_wb_cyc_o  = 1'b0;
            s_wb_stb_o  = 1'b0;
            s_wb_we_o   = 1'b0;
            m0_wb_ack_o = 1'b0;
            m0_wb_err_o = 1'b0;
            m0_wb_rty_o = 1'b0;
            m1_wb_ack_o = 1'b0;
            m1_wb_err_o = 1'b0;
            m1_wb_rty_o = 1'b0;
        end
    end

    // Owner state and round-robin history; m1 is marked last so m0 wins the first contest.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
        end
    end

endmodule

// File: tb/tb_ram_wb_arbiter_2m.sv
// Self-checking bench: scripted masters, registered-ack RAM slave model, scoreboard of accesses.
module tb_ram_wb_arbiter_2m;

    localparam logic [31:0] DKEY = 32'hA5A5_0000;

    typedef struct packed {
        logic        id;
        logic [31:0] adr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] m_adr [2];
    logic [31:0] m_wdat [2];
    logic [3:0]  m_sel [2];
    logic [1:0]  m_bte [2];
    logic [2:0]  m_cti [2];
    logic [1:0]  m_cyc, m_stb, m_we, m_ack, m_err, m_rty;
    logic [31:0] m0_dat, m1_dat;
    logic [31:0] s_adr, s_wdat, s_dat;
    logic [3:0]  s_sel;
    logic [1:0]  s_bte;
    logic [2:0]  s_cti;
    logic        s_cyc, s_stb, s_we, s_ack;
    logic [1:0]  grant;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   viol = 0;
    int   err_cnt = 0;
    logic [1:0] prev_grant = 2'b00;

    always #5 clk = ~clk;

    ram_wb_arbiter_2m #(
        .dw (32), .aw (32), .TIMEOUT (8), .FIXED_PRIO (0)
    ) dut (
        .wb_clk_i    (clk),         .wb_rst_i    (rst),
        .m0_wb_adr_i (m_adr[0]),    .m0_wb_dat_i (m_wdat[0]), .m0_wb_sel_i (m_sel[0]),
        .m0_wb_bte_i (m_bte[0]),    .m0_wb_cti_i (m_cti[0]),  .m0_wb_cyc_i (m_cyc[0]),
        .m0_wb_stb_i (m_stb[0]),    .m0_wb_we_i  (m_we[0]),   .m0_wb_ack_o (m_ack[0]),
        .m0_wb_err_o (m_err[0]),    .m0_wb_rty_o (m_rty[0]),  .m0_wb_dat_o (m0_dat),
        .m1_wb_adr_i (m_adr[1]),    .m1_wb_dat_i (m_wdat[1]), .m1_wb_sel_i (m_sel[1]),
        .m1_wb_bte_i (m_bte[1]),    .m1_wb_cti_i (m_cti[1]),  .m1_wb_cyc_i (m_cyc[1]),
        .m1_wb_stb_i (m_stb[1]),    .m1_wb_we_i  (m_we[1]),   .m1_wb_ack_o (m_ack[1]),
        .m1_wb_err_o (m_err[1]),    .m1_wb_rty_o (m_rty[1]),  .m1_wb_dat_o (m1_dat),
        .s_wb_adr_o  (s_adr),       .s_wb_dat_o  (s_wdat),    .s_wb_sel_o  (s_sel),
        .s_wb_bte_o  (s_bte),       .s_wb_cti_o  (s_cti),     .s_wb_cyc_o  (s_cyc),
        .s_wb_stb_o  (s_stb),       .s_wb_we_o   (s_we),      .s_wb_ack_i  (s_ack),
        .s_wb_err_i  (1'b0),        .s_wb_rty_i  (1'b0),      .s_wb_dat_i  (s_dat),
        .grant_o     (grant)
    );

    // RAM slave model: registered ack, one ack per beat in a burst, ack state drops on CTI end.
    assign s_dat = s_adr ^ DKEY;
    always @(posedge clk) begin
        if (rst) s_ack <= 1'b0;
        else     s_ack <= s_cyc & s_stb & ~(s_ack & ((s_cti == 3'b000) | (s_cti == 3'b111)));
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: every ack must match the next scoreboard entry; owners never swap without IDLE.
    always @(negedge clk) begin
        exp_t e;
        if (m_err != 2'b00) err_cnt++;
        if (!rst) begin
            if (prev_grant != 2'b00 && grant != 2'b00 && prev_grant != grant) viol++;
            if (grant == 2'b00 && s_cyc) viol++;
        end
        prev_grant = grant;
        if (m_ack != 2'b00) begin
            if (sb.size() == 0) begin
                check_eq("sb_unexpected_ack", {62'd0, m_ack}, 64'd0);
            end else begin
                e = sb.pop_front();
                check_eq("ack_who", {62'd0, m_ack}, e.id ? 64'd2 : 64'd1);
                check_eq("ack_grant", {62'd0, grant}, e.id ? 64'd2 : 64'd1);
                check_eq("ack_adr", {32'd0, s_adr}, {32'd0, e.adr});
                check_eq("ack_dat", {32'd0, e.id ? m1_dat : m0_dat}, {32'd0, e.adr ^ DKEY});
            end
        end
    end

    task automatic wait_ack(input int id, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_ack[id] && n < 64);
        check_eq(tag, {63'd0, m_ack[id]}, 64'd1);
    endtask

    task automatic idle_master(input int id);
        m_cyc[id] = 1'b0; m_stb[id] = 1'b0; m_we[id] = 1'b0;
        m_cti[id] = 3'b000; m_bte[id] = 2'b00;
    endtask

    // Classic single read; returns just after the completing edge with CYC dropped.
    task automatic classic(input int id, input logic [31:0] adr);
        m_adr[id] = adr; m_cti[id] = 3'b000; m_bte[id] = 2'b00;
        m_cyc[id] = 1'b1; m_stb[id] = 1'b1; m_we[id] = 1'b0;
        wait_ack(id, "classic_ack_wait");
        @(posedge clk); #1;
        idle_master(id);
    endtask

    // Incrementing WRAP4 burst of word beats, last beat flagged end-of-burst.
    task automatic burst4(input int id, input logic [31:0] base);
        logic [3:0] low;
        m_cyc[id] = 1'b1; m_stb[id] = 1'b1; m_we[id] = 1'b0; m_bte[id] = 2'b01;
        for (int k = 0; k < 4; k++) begin
            low       = base[3:0] + 4'(4 * k);
            m_adr[id] = {base[31:4], low};
            m_cti[id] = (k == 3) ? 3'b111 : 3'b010;
            wait_ack(id, "burst_ack_wait");
            @(posedge clk); #1;
        end
        idle_master(id);
    endtask

    initial begin
        int   n;
        int   gcnt;
        logic got;
        logic cyc_at_err;
        for (int i = 0; i < 2; i++) begin
            m_adr[i] = '0; m_wdat[i] = 32'h1234_5678 + i; m_sel[i] = 4'hF;
            idle_master(i);
        end

        // 1: reset held with both masters requesting; bus stays quiet.
        m_cyc = 2'b11; m_stb = 2'b11;
        repeat (5) begin
            @(negedge clk);
            check_eq("reset_quiet", {57'd0, grant, s_cyc, m_ack, m_err}, 64'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        idle_master(0); idle_master(1);

        // 2: m0 alone, one cycle of arbitration latency.
        @(posedge clk); #1;
        sb.push_back('{id: 1'b0, adr: 32'h10});
        fork
            classic(0, 32'h10);
            begin
                @(negedge clk);
                check_eq("t2_latency", {61'd0, grant, s_cyc}, 64'd0);
                @(negedge clk);
                check_eq("t2_grant", {61'd0, grant, s_cyc}, {61'd0, 2'b01, 1'b1});
                check_eq("t2_adr", {32'd0, s_adr}, 64'h10);
            end
        join

        // 3: fresh reset, both request together: m0, m1, m0, m1.
        @(posedge clk); #1; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        sb.push_back('{id: 1'b0, adr: 32'h100});
        sb.push_back('{id: 1'b1, adr: 32'h200});
        sb.push_back('{id: 1'b0, adr: 32'h104});
        sb.push_back('{id: 1'b1, adr: 32'h204});
        fork
            begin classic(0, 32'h100); classic(0, 32'h104); end
            begin classic(1, 32'h200); classic(1, 32'h204); end
        join

        // 4: m1 wrap burst is not split while m0 waits.
        sb.push_back('{id: 1'b1, adr: 32'h08});
        sb.push_back('{id: 1'b1, adr: 32'h0C});
        sb.push_back('{id: 1'b1, adr: 32'h00});
        sb.push_back('{id: 1'b1, adr: 32'h04});
        sb.push_back('{id: 1'b0, adr: 32'h40});
        fork
            burst4(1, 32'h08);
            begin repeat (2) @(posedge clk); #1; classic(0, 32'h40); end
        join

        // 5: m0 holds CYC without STB; watchdog errors it on the 8th granted cycle.
        @(posedge clk); #1;
        m_adr[0] = 32'h80; m_cti[0] = 3'b000; m_cyc[0] = 1'b1; m_stb[0] = 1'b0;
        sb.push_back('{id: 1'b1, adr: 32'h50});
        fork
            begin repeat (3) @(posedge clk); #1; classic(1, 32'h50); end
            begin
                gcnt = 0; n = 0; got = 1'b0; cyc_at_err = 1'b1;
                while (!got && n < 40) begin
                    @(negedge clk);
                    n++;
                    if (grant == 2'b01) gcnt++;
                    if (m_err[0]) begin
                        got = 1'b1;
                        cyc_at_err = s_cyc;
                    end
                end
                check_eq("t5_err_seen", {63'd0, got}, 64'd1);
                check_eq("t5_err_cycle", gcnt, 64'd8);
                check_eq("t5_slave_cyc_off", {63'd0, cyc_at_err}, 64'd0);
                @(posedge clk); #1;
                idle_master(0);
                @(negedge clk);
                check_eq("t5_idle_after", {62'd0, grant}, 64'd0);
            end
        join

        // 6: reset during beat 2 of an m0 burst; beat is dropped, m1 then served cleanly.
        @(posedge clk); #1;
        sb.push_back('{id: 1'b0, adr: 32'h20});
        m_adr[0] = 32'h20; m_cti[0] = 3'b010; m_bte[0] = 2'b01;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        wait_ack(0, "t6_beat1_wait");
        @(posedge clk); #1;
        m_adr[0] = 32'h24;
        rst = 1'b1;
        @(negedge clk);
        check_eq("t6_beat2_dropped", {62'd0, m_ack[0], m_err[0]}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_master(0);
        sb.push_back('{id: 1'b1, adr: 32'h30});
        fork
            classic(1, 32'h30);
            begin
                @(negedge clk);
                check_eq("t6_after_reset", {61'd0, grant, s_cyc}, 64'd0);
                @(negedge clk);
                check_eq("t6_m1_grant", {61'd0, grant, s_cyc}, {61'd0, 2'b10, 1'b1});
            end
        join

        repeat (4) @(posedge clk);
        check_eq("sb_drained", sb.size(), 64'd0);
        check_eq("handover_via_idle", viol, 64'd0);
        check_eq("err_count", err_cnt, 64'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
